// File: rtl/jesd204b_rx_link_sync_if.sv
// Link-side bundle between the transceiver word stream and the JESD204B RX sync FSM.
interface jesd204b_rx_link_sync_if;
  logic [31:0]  i_data;
  logic [3:0]   i_charisk;
  logic         i_byte_aligned;
  logic         o_nsync;
  logic [31:0]  o_data;
  logic         o_data_valid;
  logic         o_link_up;
  logic [1:0]   o_state;
  logic [111:0] o_ilas_cfg;
  logic         o_ilas_err;

  modport master (
    output i_data, i_charisk, i_byte_aligned,
    input  o_nsync, o_data, o_data_valid, o_link_up, o_state, o_ilas_cfg, o_ilas_err
  );
  modport slave (
    input  i_data, i_charisk, i_byte_aligned,
    output o_nsync, o_data, o_data_valid, o_link_up, o_state, o_ilas_cfg, o_ilas_err
  );
endinterface

// File: rtl/jesd204b_rx_link_sync.sv
// JESD204B RX link synchronisation: CGS /K/ counting, ILAS checking with config
// capture, and DATA pass-through with loss-of-sync detection.
module jesd204b_rx_link_sync #(
  parameter int FRAME_SIZE = 1,
  parameter int FMLC_NUM   = 32,
  parameter int CGS_K_CNT  = 4,
  parameter int MF_WORDS   = FRAME_SIZE * FMLC_NUM / 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  jesd204b_rx_link_sync_if.slave  lnk
);
  localparam int KW = $clog2(CGS_K_CNT + 1);
  localparam int WW = $clog2(MF_WORDS);

  typedef enum logic [1:0] {CGS = 2'd0, ILAS = 2'd1, DATA = 2'd2} state_t;

  state_t          state, state_n;
  logic [KW-1:0]   kcnt, kcnt_n;
  logic [WW-1:0]   widx, widx_n;
  logic [1:0]      mf, mf_n;
  logic            started, started_n;
  logic [111:0]    cfg, cfg_n;
  logic            err_n, valid_n, bad;
  logic            nsync, link_up, valid, err;
  logic [31:0]     data;

  wire [31:0] d    = lnk.i_data;
  wire [3:0]  k    = lnk.i_charisk;
  wire        al   = lnk.i_byte_aligned;
  wire        all_k = (d == 32'hBCBC_BCBC) && (k == 4'hF);
  wire        is_r = (d[7:0]   == 8'h1C) && k[0];
  wire        is_q = (d[15:8]  == 8'h9C) && k[1];
  wire        is_a = (d[31:24] == 8'h7C) && k[3];

  always_comb begin
    state_n   = state;
    kcnt_n    = kcnt;
    widx_n    = widx;
    mf_n      = mf;
    started_n = started;
    cfg_n     = cfg;
    err_n     = 1'b0;
    valid_n   = 1'b0;
    bad       = 1'b0;
    case (state)
      CGS: begin
        if (all_k && al) begin
          if (kcnt == KW'(CGS_K_CNT - 1)) state_n = ILAS;
          else kcnt_n = kcnt + 1'b1;
        end else begin
          kcnt_n = '0;
        end
      end
      ILAS: begin
        // Trailing CGS /K/ words are skipped until the first /R/ opens multiframe 0
        if (started || !all_k) begin
          started_n = 1'b1;
          if (widx == '0) begin
            if (!is_r) bad = 1'b1;
            if (mf == 2'd1) begin
              if (!is_q) bad = 1'b1;
              cfg_n[15:0] = d[31:16];
            end
          end
          if (mf == 2'd1 && widx == WW'(1)) cfg_n[47:16]  = d;
          if (mf == 2'd1 && widx == WW'(2)) cfg_n[79:48]  = d;
          if (mf == 2'd1 && widx == WW'(3)) cfg_n[111:80] = d;
          if (widx == WW'(MF_WORDS - 1)) begin
            if (!is_a) bad = 1'b1;
            widx_n = '0;
            mf_n   = mf + 2'd1;
            if (mf == 2'd3) state_n = DATA;
          end else begin
            widx_n = widx + 1'b1;
          end
          if (bad) begin
            err_n   = 1'b1;
            state_n = CGS;
          end
        end
      end
      DATA: begin
        valid_n = 1'b1;
        if (all_k) begin
          valid_n = 1'b0;
          err_n   = 1'b1;
          state_n = CGS;
        end
      end
      default: state_n = CGS;
    endcase
    // Losing comma alignment is a silent resync, overriding every other outcome
    if (!al) begin
      state_n = CGS;
      err_n   = 1'b0;
      valid_n = 1'b0;
    end
    if (state_n != ILAS) begin
      widx_n    = '0;
      mf_n      = '0;
      started_n = 1'b0;
    end
    if (state_n != CGS || state != CGS) kcnt_n = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= CGS;
      kcnt    <= '0;
      widx    <= '0;
      mf      <= '0;
      started <= 1'b0;
      cfg     <= '0;
      nsync   <= 1'b0;
      link_up <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
      data    <= '0;
    end else begin
      state   <= state_n;
      kcnt    <= kcnt_n;
      widx    <= widx_n;
      mf      <= mf_n;
      started <= started_n;
      cfg     <= cfg_n;
      nsync   <= (state_n != CGS);
      link_up <= (state_n == DATA);
      valid   <= valid_n;
      err     <= err_n;
      data    <= d;
    end
  end

  assign lnk.o_nsync      = nsync;
  assign lnk.o_data       = data;
  assign lnk.o_data_valid = valid;
  assign lnk.o_link_up    = link_up;
  assign lnk.o_state      = state;
  assign lnk.o_ilas_cfg   = cfg;
  assign lnk.o_ilas_err   = err;
endmodule

// File: tb/tb_jesd204b_rx_link_sync.sv
// Directed bench for the JESD204B RX sync FSM: CGS, ILAS capture/errors, DATA, resync and reset.
module tb_jesd204b_rx_link_sync;
  localparam int MFW = 8;
  localparam logic [111:0] CFG_EXP = 112'h0E0D0C0B0A090807060504030201;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  jesd204b_rx_link_sync_if lnk();

  jesd204b_rx_link_sync dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .lnk     (lnk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word, let it be sampled, return 1ns after the edge
  task automatic step(input logic [31:0] d, input logic [3:0] k, input logic a);
    lnk.i_data         = d;
    lnk.i_charisk      = k;
    lnk.i_byte_aligned = a;
    @(posedge clk);
    #1;
  endtask

  task automatic kwords(input int n);
    for (int i = 0; i < n; i++) step(32'hBCBC_BCBC, 4'hF, 1'b1);
  endtask

  // ILAS word i (multiframe i/MFW); 'bad' corrupts /A/ on a last word or /Q/ on word 0
  task automatic ilas_words(input int n, input int bad);
    logic [31:0] d;
    logic [3:0]  k;
    int m, w;
    for (int i = 0; i < n; i++) begin
      m = i / MFW;
      w = i % MFW;
      d = {8'h30, 8'h20, 8'h10, 8'(i)};
      k = 4'h0;
      if (w == 0) begin
        d[7:0] = 8'h1C; k[0] = 1'b1;
        if (m == 1) begin d[15:8] = 8'h9C; k[1] = 1'b1; d[31:16] = 16'h0201; end
      end
      if (m == 1 && w == 1) d = 32'h0605_0403;
      if (m == 1 && w == 2) d = 32'h0A09_0807;
      if (m == 1 && w == 3) d = 32'h0E0D_0C0B;
      if (w == MFW - 1) begin d[31:24] = 8'h7C; k[3] = 1'b1; end
      if (i == bad) begin
        if (w == MFW - 1) begin d[31:24] = 8'h00; k[3] = 1'b0; end
        else begin d[15:8] = 8'h00; k[1] = 1'b0; end
      end
      step(d, k, 1'b1);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 112'(lnk.o_state), 112'd0);
    chk({tag, "_nsync"}, 112'(lnk.o_nsync), 112'd0);
    chk({tag, "_data"},  112'(lnk.o_data), 112'd0);
    chk({tag, "_valid"}, 112'(lnk.o_data_valid), 112'd0);
    chk({tag, "_link"},  112'(lnk.o_link_up), 112'd0);
    chk({tag, "_err"},   112'(lnk.o_ilas_err), 112'd0);
    chk({tag, "_cfg"},   lnk.o_ilas_cfg, 112'd0);
  endtask

  initial begin
    lnk.i_data = '0; lnk.i_charisk = '0; lnk.i_byte_aligned = 1'b1;
    // Reset
    rst_n = 1'b0;
    step(32'hBCBC_BCBC, 4'hF, 1'b1);
    step(32'hBCBC_BCBC, 4'hF, 1'b1);
    chk_reset("rst");
    rst_n = 1'b1;

    // Unaligned /K/ words do not count
    for (int i = 0; i < 5; i++) step(32'hBCBC_BCBC, 4'hF, 1'b0);
    chk("cgs_unaligned_nsync", 112'(lnk.o_nsync), 112'd0);
    // Three /K/ then a data word clears the count
    kwords(3);
    step(32'h0000_0000, 4'h0, 1'b1);
    chk("cgs_broken_nsync", 112'(lnk.o_nsync), 112'd0);
    kwords(3);
    chk("cgs_3rd_nsync", 112'(lnk.o_nsync), 112'd0);
    kwords(1);
    chk("cgs_4th_nsync", 112'(lnk.o_nsync), 112'd1);
    chk("cgs_4th_state", 112'(lnk.o_state), 112'd1);
    kwords(2);
    chk("ilas_kskip_state", 112'(lnk.o_state), 112'd1);

    // Full ILAS into DATA
    ilas_words(4 * MFW - 1, -1);
    chk("ilas_31_state", 112'(lnk.o_state), 112'd1);
    chk("ilas_31_link", 112'(lnk.o_link_up), 112'd0);
    step(32'h7C30_2000, 4'h8, 1'b1);
    chk("ilas_32_state", 112'(lnk.o_state), 112'd2);
    chk("ilas_32_link", 112'(lnk.o_link_up), 112'd1);
    chk("ilas_32_valid", 112'(lnk.o_data_valid), 112'd0);
    chk("ilas_cfg", lnk.o_ilas_cfg, CFG_EXP);

    // DATA pass-through
    step(32'h1234_5678, 4'h0, 1'b1);
    chk("data1", 112'(lnk.o_data), 112'h1234_5678);
    chk("data1_valid", 112'(lnk.o_data_valid), 112'd1);
    step(32'hCAFE_F00D, 4'h2, 1'b1);
    chk("data2", 112'(lnk.o_data), 112'hCAFE_F00D);
    chk("data2_valid", 112'(lnk.o_data_valid), 112'd1);
    // All-/K/ word in DATA
    kwords(1);
    chk("data_k_err", 112'(lnk.o_ilas_err), 112'd1);
    chk("data_k_valid", 112'(lnk.o_data_valid), 112'd0);
    chk("data_k_state", 112'(lnk.o_state), 112'd0);
    chk("data_k_nsync", 112'(lnk.o_nsync), 112'd0);
    kwords(1);
    chk("data_k_err_clr", 112'(lnk.o_ilas_err), 112'd0);

    // Missing /A/ at multiframe 2 word 7
    kwords(4);
    chk("resync_state", 112'(lnk.o_state), 112'd1);
    ilas_words(3 * MFW - 1, 3 * MFW - 1);
    chk("bad_a_pre_err", 112'(lnk.o_ilas_err), 112'd0);
    chk("bad_a_pre_state", 112'(lnk.o_state), 112'd1);
    step(32'h0030_2000, 4'h0, 1'b1);
    chk("bad_a_err", 112'(lnk.o_ilas_err), 112'd1);
    chk("bad_a_nsync", 112'(lnk.o_nsync), 112'd0);
    chk("bad_a_state", 112'(lnk.o_state), 112'd0);

    // Missing /Q/ in multiframe 1
    kwords(1);
    kwords(4);
    ilas_words(MFW + 1, MFW);
    chk("bad_q_err", 112'(lnk.o_ilas_err), 112'd1);
    chk("bad_q_state", 112'(lnk.o_state), 112'd0);

    // Alignment loss in DATA
    kwords(5);
    ilas_words(4 * MFW, -1);
    chk("al_pre_link", 112'(lnk.o_link_up), 112'd1);
    step(32'hDEAD_BEEF, 4'h0, 1'b0);
    chk("al_state", 112'(lnk.o_state), 112'd0);
    chk("al_link", 112'(lnk.o_link_up), 112'd0);
    chk("al_err", 112'(lnk.o_ilas_err), 112'd0);
    chk("al_cfg_hold", lnk.o_ilas_cfg, CFG_EXP);

    // Reset during multiframe 1
    kwords(4);
    ilas_words(MFW + 3, -1);
    rst_n = 1'b0;
    step(32'h0E0D_0C0B, 4'h0, 1'b1);
    chk_reset("mid_rst");
    rst_n = 1'b1;
    kwords(4);
    ilas_words(4 * MFW, -1);
    chk("post_rst_state", 112'(lnk.o_state), 112'd2);
    chk("post_rst_link", 112'(lnk.o_link_up), 112'd1);
    chk("post_rst_cfg", lnk.o_ilas_cfg, CFG_EXP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jesd204b_rx_link_sync.md
JESD204B_RX_LINK_SYNC -- requirements
Module: jesd204b_rx_link_sync

Interface
REQ-001 SHALL have parameter FRAME_SIZE, default 1, meaning octets per frame (F).
REQ-002 SHALL have parameter FMLC_NUM, default 32, meaning frames per multiframe (K).
REQ-003 SHALL have parameter CGS_K_CNT, default 4, meaning consecutive all-/K/ words required to pass CGS.
REQ-004 SHALL have parameter MF_WORDS = FRAME_SIZE*FMLC_NUM/4 (derived), meaning 32-bit words per multiframe; legal only if it is an integer >= 4.
REQ-005 SHALL have one clock and a synchronous, active-low reset: i_clk  in  1  rx user clock (rxusrclk2 domain); i_rst_n  in  1  synchronous active-low reset.
REQ-006 i_data  in  32  byte-aligned transceiver word, octet 0 in [7:0], earliest on the wire.
REQ-007 i_charisk  in  4  per-octet K-character flag, bit n for octet n.
REQ-008 i_byte_aligned  in  1  transceiver comma-alignment status.
REQ-009 o_nsync  out  1  JESD204B SYNC~, low requests resynchronisation.
REQ-010 o_data  out  32  user data word; o_data_valid  out  1  o_data qualifier.
REQ-011 o_link_up  out  1  high in DATA state; o_state  out  2  current state encoding.
REQ-012 o_ilas_cfg  out  112  14 ILAS configuration octets, octet 0 in [7:0]; o_ilas_err  out  1  one-cycle error pulse.

Function
REQ-013 Constants: /K/=0xBC, /R/=0x1C, /A/=0x7C, /Q/=0x9C, each valid only with the matching charisk bit set.
REQ-014 States: CGS=0, ILAS=1, DATA=2; encoding 3 unused; any illegal state SHALL return to CGS.
REQ-015 All inputs SHALL be sampled on i_clk rising edge; all outputs SHALL be registered.
REQ-016 CGS: o_nsync=0; counter kcnt SHALL increment on each word with all four octets /K/ and i_byte_aligned=1, and clear on any other word.
REQ-017 CGS -> ILAS when kcnt reaches CGS_K_CNT; o_nsync SHALL go high in the cycle after the CGS_K_CNT-th qualifying word.
REQ-018 In ILAS, /K/-only words before the first /R/ SHALL be ignored; a word with /R/ in octet 0 SHALL start multiframe 0 at word index 0.
REQ-019 ILAS word index SHALL count 0..MF_WORDS-1 and wrap to 0; multiframe counter SHALL count 0..3.
REQ-020 Every ILAS multiframe SHALL have /R/ at octet 0 of word 0 and /A/ at octet 3 of word MF_WORDS-1.
REQ-021 Multiframe 1 SHALL have /Q/ at octet 1 of word 0; octets 2..3 of word 0 and all octets of words 1..3 SHALL be latched into o_ilas_cfg.
REQ-022 On /A/ closing multiframe 3, the state SHALL move to DATA in the next cycle.
REQ-023 Any REQ-020/021 violation SHALL pulse o_ilas_err for one cycle and return to CGS, with o_nsync=0 from the next cycle.
REQ-024 DATA: o_data SHALL equal i_data delayed one cycle; o_data_valid=1 for every DATA word.
REQ-025 DATA: a word with all four octets /K/ SHALL pulse o_ilas_err, force o_data_valid=0 for that word, and return to CGS.
REQ-026 i_byte_aligned=0 in any state SHALL send the FSM to CGS in the next cycle without pulsing o_ilas_err; this takes priority over REQ-017/022/025.
REQ-027 Entering CGS SHALL clear kcnt, word index and multiframe counter; o_ilas_cfg SHALL hold its last value until overwritten.
REQ-028 o_data_valid SHALL be 0 in CGS and ILAS.

Reset
REQ-029 With i_rst_n=0 at a rising edge: state=CGS, o_nsync=0, o_data=0, o_data_valid=0, o_link_up=0, o_ilas_err=0, o_ilas_cfg=0, all counters 0.
REQ-030 Reset SHALL override all other events in the same cycle, including mid-ILAS and in DATA.

Verification
REQ-031 4 words 0xBCBCBCBC, charisk 0xF, aligned=1 -> o_nsync rises 1 cycle after the 4th word; 3 such words followed by 0x00000000 -> o_nsync stays 0.
REQ-032 Full ILAS with defaults (8 words/multiframe), config octets 0x01..0x0E -> o_ilas_cfg=0x0E0D...01, DATA entered after the 32nd ILAS word, o_link_up=1.
REQ-033 DATA word 0x12345678, charisk 0x0 -> o_data=0x12345678, o_data_valid=1 one cycle later.
REQ-034 Multiframe 2 word 7 octet 3 = 0x00 instead of /A/ -> o_ilas_err pulse, o_nsync=0, state=CGS.
REQ-035 i_byte_aligned dropped in DATA -> next cycle state=CGS, o_link_up=0, o_ilas_err stays 0.
REQ-036 i_rst_n=0 during ILAS multiframe 1 -> all outputs at REQ-029 values; a subsequent full CGS+ILAS reaches DATA.
